// File: rtl/collision_scanner.sv
// Frame-strobed bird/pipe collision scanner: snapshots the scene, checks one pipe per clock.
// Optional pass-score counter is built when COLLISION_SCORE_EN is defined.
module collision_scanner #(
  parameter int unsigned COORD_W   = 10,
  parameter int unsigned NUM_PIPES = 4,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned SCORE_W   = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           frame_start,
  input  logic                           clear,
  input  logic [COORD_W-1:0]             bird_x,
  input  logic [COORD_W-1:0]             bird_y,
  input  logic [COORD_W-1:0]             bird_hw,
  input  logic [COORD_W-1:0]             bird_hh,
  input  logic [NUM_PIPES*COORD_W-1:0]   pipe_x,
  input  logic [COORD_W-1:0]             pipe_hw,
  input  logic [NUM_PIPES*COORD_W-1:0]   gap_top,
  input  logic [NUM_PIPES*COORD_W-1:0]   gap_bot,
  output logic                           busy,
  output logic                           done,
  output logic                           hit,
  output logic [NUM_PIPES-1:0]           hit_mask,
  output logic                           bound_hit,
  output logic                           crashed,
  output logic [SCORE_W-1:0]             score,
  output logic                           overrun
);

  localparam int unsigned EW    = COORD_W + 2;
  localparam int unsigned IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_PIPES - 1);
  localparam logic signed [EW-1:0] FLOOR_Y  = EW'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [COORD_W-1:0]             bx_q, bx_d, by_q, by_d, bhw_q, bhw_d, bhh_q, bhh_d, phw_q, phw_d;
  logic [NUM_PIPES*COORD_W-1:0]   px_q, px_d, gt_q, gt_d, gb_q, gb_d;
  logic [NUM_PIPES-1:0]           acc_q, acc_d, hit_mask_q, hit_mask_d;
  logic                           hit_q, hit_d, bound_hit_q, bound_hit_d;
  logic                           crashed_q, crashed_d, overrun_q, overrun_d;

  logic signed [EW-1:0] b_l, b_r, b_t, b_b, p_l, p_r, g_t, g_b;
  logic                 collide, bound;

  function automatic logic signed [EW-1:0] ext(input logic [COORD_W-1:0] v);
    return signed'({2'b00, v});
  endfunction

  always_comb begin
    b_l = ext(bx_q) - ext(bhw_q);
    b_r = ext(bx_q) + ext(bhw_q);
    b_t = ext(by_q) - ext(bhh_q);
    b_b = ext(by_q) + ext(bhh_q);
    p_l = ext(px_q[idx_q*COORD_W +: COORD_W]) - ext(phw_q);
    p_r = ext(px_q[idx_q*COORD_W +: COORD_W]) + ext(phw_q);
    g_t = ext(gt_q[idx_q*COORD_W +: COORD_W]);
    g_b = ext(gb_q[idx_q*COORD_W +: COORD_W]);
    collide = (b_r > p_l) && (b_l < p_r) && ((b_t < g_t) || (b_b > g_b));
    // Sign bit of the widened top edge means the bird pokes above y = 0.
    bound   = b_t[EW-1] || (b_b > FLOOR_Y);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bx_d        = bx_q;
    by_d        = by_q;
    bhw_d       = bhw_q;
    bhh_d       = bhh_q;
    phw_d       = phw_q;
    px_d        = px_q;
    gt_d        = gt_q;
    gb_d        = gb_q;
    acc_d       = acc_q;
    hit_mask_d  = hit_mask_q;
    hit_d       = hit_q;
    bound_hit_d = bound_hit_q;
    crashed_d   = crashed_q;
    overrun_d   = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          bx_d    = bird_x;
          by_d    = bird_y;
          bhw_d   = bird_hw;
          bhh_d   = bird_hh;
          phw_d   = pipe_hw;
          px_d    = pipe_x;
          gt_d    = gap_top;
          gb_d    = gap_bot;
          acc_d   = '0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        acc_d[idx_q] = collide;
        if (idx_q == LAST_IDX) begin
          // Results are registered on entry to DONE so they are valid while done is high.
          state_d     = DONE;
          hit_mask_d  = acc_d;
          hit_d       = |acc_d;
          bound_hit_d = bound;
          crashed_d   = crashed_q | (|acc_d) | bound;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (frame_start && (state_q != IDLE)) overrun_d = 1'b1;
    if (clear) begin
      crashed_d = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      bhw_q       <= '0;
      bhh_q       <= '0;
      phw_q       <= '0;
      px_q        <= '0;
      gt_q        <= '0;
      gb_q        <= '0;
      acc_q       <= '0;
      hit_mask_q  <= '0;
      hit_q       <= 1'b0;
      bound_hit_q <= 1'b0;
      crashed_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      bhw_q       <= bhw_d;
      bhh_q       <= bhh_d;
      phw_q       <= phw_d;
      px_q        <= px_d;
      gt_q        <= gt_d;
      gb_q        <= gb_d;
      acc_q       <= acc_d;
      hit_mask_q  <= hit_mask_d;
      hit_q       <= hit_d;
      bound_hit_q <= bound_hit_d;
      crashed_q   <= crashed_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef COLLISION_SCORE_EN
  logic [NUM_PIPES-1:0] passed_q, passed_d;
  logic [SCORE_W-1:0]   score_q, score_d;

  // passed[i] re-arms once the pipe is seen to the right of the bird again (respawn).
  always_comb begin
    passed_d = passed_q;
    score_d  = score_q;
    if ((state_q == SCAN) && !crashed_q) begin
      if (b_l >= p_r) begin
        if (!passed_q[idx_q]) begin
          passed_d[idx_q] = 1'b1;
          if (score_q != '1) score_d = score_q + 1'b1;
        end
      end else begin
        passed_d[idx_q] = 1'b0;
      end
    end
    if (clear) begin
      passed_d = '0;
      score_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      passed_q <= '0;
      score_q  <= '0;
    end else begin
      passed_q <= passed_d;
      score_q  <= score_d;
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign hit       = hit_q;
  assign hit_mask  = hit_mask_q;
  assign bound_hit = bound_hit_q;
  assign crashed   = crashed_q;
  assign overrun   = overrun_q;

endmodule
